// File: rtl/alu_iter_pkg.sv
// Shared funct3/branch constants plus the iterative ALU's state and op-class types.
// The MUL state exists only when ALU_ITER_MUL_EN is defined.
package alu_iter_pkg;

  localparam logic [2:0] FUNC_ADD  = 3'b000;
  localparam logic [2:0] FUNC_SLL  = 3'b001;
  localparam logic [2:0] FUNC_SLT  = 3'b010;
  localparam logic [2:0] FUNC_SLTU = 3'b011;
  localparam logic [2:0] FUNC_XOR  = 3'b100;
  localparam logic [2:0] FUNC_SR   = 3'b101;
  localparam logic [2:0] FUNC_OR   = 3'b110;
  localparam logic [2:0] FUNC_AND  = 3'b111;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ADDER_ADD = 1'b0,
    ADDER_SUB = 1'b1
  } adderOp_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_ADD   = 3'd2,
`ifdef ALU_ITER_MUL_EN
    ST_MUL   = 3'd3,
`endif
    ST_FIN   = 3'd4
  } aluIterState_t;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_SHIFT  = 3'd1,
    CLS_SHADD  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_MUL    = 3'd4
  } aluIterClass_t;

  function automatic logic is_shift_f3(input logic [2:0] f3);
    return (f3 == FUNC_SLL) || (f3 == FUNC_SR);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Start/done request bus between the execute stage (master) and alu_iter (slave).
// The mul request line exists only when ALU_ITER_MUL_EN is defined.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [2:0]       f3;
  logic             arith_bit;
  logic             shadd;
  logic             branch;
`ifdef ALU_ITER_MUL_EN
  logic             mul;
`endif
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;

  modport master (
    output start, src_a, src_b, f3, arith_bit, shadd, branch,
`ifdef ALU_ITER_MUL_EN
    output mul,
`endif
    input  out, busy, done
  );

  modport slave (
    input  start, src_a, src_b, f3, arith_bit, shadd, branch,
`ifdef ALU_ITER_MUL_EN
    input  mul,
`endif
    output out, busy, done
  );
endinterface

// File: rtl/alu_iter_shift_step.sv
// One shift iteration: moves acc by min(rem, SHIFT_STEP) and returns the remaining distance.
// Shared by plain shifts (either direction) and the left shift of shNadd.
module alu_iter_shift_step #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4,
  parameter int WSHAM      = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WSHAM-1:0] i_rem,
  input  logic             i_right,
  input  logic             i_arith,
  output logic [WIDTH-1:0] o_acc,
  output logic [WSHAM-1:0] o_rem
);

  // SHIFT_STEP may equal WIDTH, so the step needs one bit more than rem.
  localparam logic [WSHAM:0] STEP_MAX = (WSHAM+1)'(SHIFT_STEP);

  logic [WSHAM:0] w_rem_ext;
  logic [WSHAM:0] w_step;

  // Step selection and the shift itself.
  always_comb begin
    w_rem_ext = {1'b0, i_rem};
    if (w_rem_ext < STEP_MAX) begin
      w_step = w_rem_ext;
    end else begin
      w_step = STEP_MAX;
    end
    o_rem = i_rem - w_step[WSHAM-1:0];
    if (!i_right) begin
      o_acc = i_acc << w_step;
    end else if (i_arith) begin
      o_acc = $unsigned($signed(i_acc) >>> w_step);
    end else begin
      o_acc = i_acc >> w_step;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative execute-stage ALU with start/done handshake, multi-bit shift steps and shNadd.
// Defining ALU_ITER_MUL_EN adds a shift-add low-word multiplier with early exit.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 4,
  parameter int WSHAM      = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_iter_if.slave bus
);

  aluIterState_t    r_state, w_state_nx;
  aluIterClass_t    r_cls, w_cls_nx, w_cls_in;
  adderOp_t         w_adder_op;
  logic [WIDTH-1:0] r_acc, w_acc_nx;
  logic [WIDTH-1:0] r_b, w_b_nx;
  logic [WIDTH-1:0] r_out, w_out_nx;
  logic [WSHAM-1:0] r_rem, w_rem_nx;
  logic [2:0]       r_f3, w_f3_nx;
  logic             r_arith, w_arith_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic             w_accept;
  logic             w_mul_in;
  logic             w_taken;
  logic [WIDTH-1:0] w_alu_res;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_sh_acc;
  logic [WSHAM-1:0] w_sh_rem;
  logic             w_sh_right;
`ifdef ALU_ITER_MUL_EN
  logic [WIDTH-1:0] r_mcand, w_mcand_nx;

  assign w_mul_in = bus.mul;
`else
  assign w_mul_in = 1'b0;
`endif

  assign bus.out  = r_out;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

  // The done cycle also blocks acceptance, so back-to-back issue needs one idle cycle.
  assign w_accept   = bus.start && !r_busy && !r_done && (r_state == ST_IDLE);
  assign w_sh_right = (r_cls == CLS_SHIFT) && (r_f3 == FUNC_SR);

  alu_iter_shift_step #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP),
    .WSHAM      (WSHAM)
  ) u_shift_step (
    .i_acc   (r_acc),
    .i_rem   (r_rem),
    .i_right (w_sh_right),
    .i_arith (r_arith),
    .o_acc   (w_sh_acc),
    .o_rem   (w_sh_rem)
  );

  // Op-class decode of the incoming request: mul > shadd > branch > f3.
  always_comb begin
    w_cls_in = CLS_ALU;
    if (w_mul_in) begin
      w_cls_in = CLS_MUL;
    end else if (bus.shadd) begin
      w_cls_in = CLS_SHADD;
    end else if (bus.branch) begin
      w_cls_in = CLS_BRANCH;
    end else if (is_shift_f3(bus.f3)) begin
      w_cls_in = CLS_SHIFT;
    end else begin
      w_cls_in = CLS_ALU;
    end
  end

  // Branch condition on the latched operands.
  always_comb begin
    w_taken = 1'b0;
    case (r_f3)
      BR_BEQ:  w_taken = (r_acc == r_b);
      BR_BNE:  w_taken = (r_acc != r_b);
      BR_BLT:  w_taken = ($signed(r_acc) < $signed(r_b));
      BR_BGE:  w_taken = ($signed(r_acc) >= $signed(r_b));
      BR_BLTU: w_taken = (r_acc < r_b);
      BR_BGEU: w_taken = (r_acc >= r_b);
      default: w_taken = 1'b0;
    endcase
  end

  // Single-step ALU result and final result selection by op class.
  always_comb begin
    w_alu_res  = '0;
    w_result   = r_acc;
    w_adder_op = r_arith ? ADDER_SUB : ADDER_ADD;
    case (r_f3)
      FUNC_ADD:  w_alu_res = (w_adder_op == ADDER_SUB) ? (r_acc - r_b) : (r_acc + r_b);
      FUNC_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_acc) < $signed(r_b))};
      FUNC_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (r_acc < r_b)};
      FUNC_XOR:  w_alu_res = r_acc ^ r_b;
      FUNC_OR:   w_alu_res = r_acc | r_b;
      FUNC_AND:  w_alu_res = r_acc & r_b;
      default:   w_alu_res = '0;
    endcase
    case (r_cls)
      CLS_ALU:    w_result = w_alu_res;
      CLS_BRANCH: w_result = {{(WIDTH-1){1'b0}}, w_taken};
      default:    w_result = r_acc;
    endcase
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nx = r_state;
    w_cls_nx   = r_cls;
    w_acc_nx   = r_acc;
    w_b_nx     = r_b;
    w_rem_nx   = r_rem;
    w_f3_nx    = r_f3;
    w_arith_nx = r_arith;
    w_out_nx   = r_out;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
`ifdef ALU_ITER_MUL_EN
    w_mcand_nx = r_mcand;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cls_nx   = w_cls_in;
          w_acc_nx   = bus.src_a;
          w_b_nx     = bus.src_b;
          w_f3_nx    = bus.f3;
          w_arith_nx = bus.arith_bit;
          w_busy_nx  = 1'b1;
          w_rem_nx   = bus.src_b[WSHAM-1:0];
`ifdef ALU_ITER_MUL_EN
          w_mcand_nx = bus.src_a;
`endif
          case (w_cls_in)
            CLS_SHIFT: begin
              if (bus.src_b[WSHAM-1:0] != '0) begin
                w_state_nx = ST_SHIFT;
              end else begin
                w_state_nx = ST_FIN;
              end
            end
            CLS_SHADD: begin
              w_rem_nx   = WSHAM'(bus.f3[2:1]);
              w_state_nx = ST_SHIFT;
            end
`ifdef ALU_ITER_MUL_EN
            CLS_MUL: begin
              w_acc_nx   = '0;
              w_state_nx = ST_MUL;
            end
`endif
            default: w_state_nx = ST_FIN;
          endcase
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_acc_nx = w_sh_acc;
        w_rem_nx = w_sh_rem;
        if (w_sh_rem != '0) begin
          w_state_nx = ST_SHIFT;
        end else if (r_cls == CLS_SHADD) begin
          w_state_nx = ST_ADD;
        end else begin
          w_state_nx = ST_FIN;
        end
      end
      ST_ADD: begin
        w_acc_nx   = r_acc + r_b;
        w_state_nx = ST_FIN;
      end
`ifdef ALU_ITER_MUL_EN
      ST_MUL: begin
        if (r_b[0]) begin
          w_acc_nx = r_acc + r_mcand;
        end else begin
          w_acc_nx = r_acc;
        end
        w_mcand_nx = r_mcand << 1;
        w_b_nx     = r_b >> 1;
        if (r_b[WIDTH-1:1] == '0) begin
          w_state_nx = ST_FIN;
        end else begin
          w_state_nx = ST_MUL;
        end
      end
`endif
      ST_FIN: begin
        w_out_nx   = w_result;
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cls   <= CLS_ALU;
      r_acc   <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_f3    <= 3'b000;
      r_arith <= 1'b0;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef ALU_ITER_MUL_EN
      r_mcand <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_cls   <= w_cls_nx;
      r_acc   <= w_acc_nx;
      r_b     <= w_b_nx;
      r_rem   <= w_rem_nx;
      r_f3    <= w_f3_nx;
      r_arith <= w_arith_nx;
      r_out   <= w_out_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
`ifdef ALU_ITER_MUL_EN
      r_mcand <= w_mcand_nx;
`endif
    end
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised successor to the single-step iterative ALU, driven by a start/done handshake.
- Adds a configurable shift distance per cycle (SHIFT_STEP), a registered result with an explicit busy flag, and a shift-then-add path for SHADD.
- Optionally adds an iterative low-word multiplier.
- Sits in the execute stage. The core issues one operation and stalls until done.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHIFT_STEP, 4, maximum shift distance per cycle; power of two, 1..WIDTH.
- WSHAM, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  issue pulse; accepted only when busy=0.
- src_a  in  WIDTH  operand A.
- src_b  in  WIDTH  operand B.
- f3  in  3  RISC-V funct3.
- arith_bit  in  1  SUB/SRA select (funct7[5]).
- shadd  in  1  shNadd operation; shift amount is f3[2:1].
- branch  in  1  branch compare; f3 is the branch funct3.
- mul  in  1  MUL operation (present only with ALU_ITER_MUL_EN).
- out  out  WIDTH  registered result; held until the next accepted start.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse when out becomes valid.

Behaviour:
- Reset: state=IDLE; out=0, busy=0, done=0; all internal operand and count registers =0.
- Reset is asynchronous and may arrive mid-operation. The operation is abandoned and no done pulse is produced.
- Accept: start && !busy latches src_a, src_b, f3, arith_bit and the op class.
- start while busy=1 is ignored; it is not queued and does not disturb the operation.
- States: IDLE, SHIFT, ADD, MUL, FIN.
- IDLE: on accept, go to the first state for the op class:
  - pure shift with shamt≠0 → SHIFT;
  - shadd → SHIFT;
  - mul → MUL;
  - everything else → FIN.
- SHIFT: each cycle, acc is shifted by step = min(rem, SHIFT_STEP) and rem -= step.
  - Right shifts fill with acc[WIDTH-1] when arith_bit=1, else with 0. Left shifts fill with 0.
  - When rem reaches 0: shadd → ADD; otherwise → FIN.
- ADD: acc = acc + b (wrap modulo 2^WIDTH), then → FIN.
- FIN: out ← result, done=1 for exactly one cycle, busy=0 in that same cycle; then → IDLE.
- busy=1 from the cycle after accept up to, but not including, the FIN cycle.
- A new start is accepted in the cycle after done at the earliest. Accepting start in the FIN cycle itself is not allowed.
- Latency, in clocks from the accept edge to the done cycle:
  - single-step ops (add, sub, slt, sltu, and, or, xor, branch) and shifts with shamt=0: 1;
  - shifts: 1 + ceil(shamt/SHIFT_STEP);
  - shadd: 1 + 1 + 1 = 3.
- Shift amount is src_b[WSHAM-1:0]. Upper bits of src_b are ignored.
- Shift direction: f3=SLL shifts left, f3=SR shifts right.
- Single-step ops:
  - add / sub (sub when arith_bit=1);
  - slt / sltu produce zero-extended 0 or 1;
  - and / or / xor.
- Branch: out = {WIDTH-1 zeros, taken}, where taken follows BEQ/BNE/BLT/BGE/BLTU/BGEU for f3. Branch takes priority over the f3 ALU decode.
- Op-class priority when several flags are set: mul > shadd > branch > f3 decode.
- shadd with f3[2:1]=00 is treated as shift by 0. The result is a+b, still 3 cycles.
- Undefined f3 in pure-ALU mode produces out=0 and never hangs.

Optional Feature:
- Macro: ALU_ITER_MUL_EN.
- With the macro defined:
  - the mul port and the MUL state exist;
  - MUL is shift-add, one multiplier bit per cycle, and returns the low WIDTH bits;
  - the multiplier shifts right and the multiplicand shifts left each cycle;
  - the state exits to FIN early when the remaining multiplier bits are 0, so the worst case is WIDTH+1 cycles and a=anything, b=0 takes 2 cycles.
- Without the macro: the mul port is absent and no MUL logic is synthesised.

Decomposition:
- Shared package (existing): FUNC_* funct3 constants, branch funct3 constants, adderOp_t, word_t.
- New package entries: aluIterState_t enum and aluIterClass_t (ALU, SHIFT, SHADD, BRANCH, MUL).
- One sub-module, shift_step: combinational; takes acc, rem, right and arith inputs; returns the shifted acc and the next rem. It is reused for both SHIFT and SHADD.

Test Plan:
- Reset mid-shift: SLL a=1, b=31; assert rst_n=0 on cycle 3 → out=0, busy=0, no done pulse. Then ADD 5+7 → done after 1 cycle, out=12.
- Shift latency: SRA a=0x80000000, b=9, SHIFT_STEP=4 → done in cycle 4, out=0xFFC00000. Same with b=0 → done in cycle 1, out=a.
- Shadd: f3[2:1]=10, a=3, b=0x10 → done in cycle 3, out=0x1C. Wrap case a=0xFFFFFFFF, f3[2:1]=01, b=2 → out=0x00000000.
- Branch and ignored start: BLTU a=1, b=0xFFFFFFFF → out=1. start held high through a 9-cycle shift → exactly one done pulse, and the second op is accepted only after done.
- With ALU_ITER_MUL_EN: a=0x12345678, b=0x10 → out=0x23456780, done in cycle 6. a=7, b=0 → out=0, done in cycle 2.
- Logic and compare sweep with random a and b: AND, OR, XOR, SLT, SLTU each match a reference model with 1-cycle latency; done is never asserted while busy=1.
